// File: rtl/lfsr_rx_checker.sv
// -----------------------------------------------------------------------------
// lfsr_rx_checker
//
// Receive-side checker for an 8-bit LFSR word stream, where
// next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}.
// A new word is marked by any transition on the asynchronous strobe tog_in.
// The strobe is synchronised, and data_in is captured on the third rising
// edge after the transition. An FSM (HUNT -> VERIFY -> LOCKED) then tracks the
// stream. In LOCKED, mismatches are counted, and the predictor free-runs
// (flywheel) until the loss threshold is reached.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst_n        : synchronous active-low reset
//   ena          : enable; sample events are ignored while low
//   tog_in       : asynchronous toggle strobe, one transition per word
//   data_in[7:0] : received word, stable around each strobe transition
//   clear_err    : synchronous clear of err_count, wins over an increment
//   sample_valid : one-cycle pulse per accepted sample
//   sample_data  : last captured word
//   locked       : high while in LOCKED
//   err_pulse    : one-cycle pulse per mismatch while LOCKED
//   err_count    : saturating mismatch count
// -----------------------------------------------------------------------------
module lfsr_rx_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tog_in,
  input  logic [7:0] data_in,
  input  logic       clear_err,
  output logic       sample_valid,
  output logic [7:0] sample_data,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] pred_q, pred_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       s1_q, s2_q, s3_q;
  logic       sample_valid_q, sample_valid_d;
  logic [7:0] sample_data_q, sample_data_d;
  logic       locked_q, locked_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_count_q, err_count_d;

  logic       sample_evt;
  logic       err_inc;
  logic [7:0] expected;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

  // s3 always follows s2, even while disabled, so a strobe seen during
  // ena=0 is consumed rather than replayed when ena returns high.
  assign sample_evt = (s2_q ^ s3_q) & ena;
  assign expected   = lfsr_next(pred_q);
  assign match_inc  = match_cnt_q + 4'd1;
  assign miss_inc   = miss_cnt_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    pred_d         = pred_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    err_pulse_d    = 1'b0;
    err_inc        = 1'b0;

    if (sample_evt) begin
      sample_valid_d = 1'b1;
      sample_data_d  = data_in;
      case (state_q)
        HUNT: begin
          // An all-zero word is the LFSR lock-up value and cannot seed a stream.
          if (data_in != 8'h00) begin
            pred_d      = data_in;
            match_cnt_d = 4'd0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == expected) begin
            pred_d      = data_in;
            match_cnt_d = match_inc;
            if (match_inc == LOCK_CNT) begin
              state_d    = LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else if (data_in == 8'h00) begin
            state_d = HUNT;
          end else begin
            // Re-seed from the new word, so a stream that starts mid-run
            // still locks.
            pred_d      = data_in;
            match_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          if (data_in == expected) begin
            pred_d     = data_in;
            miss_cnt_d = 4'd0;
          end else begin
            // Flywheel: advance the prediction and ignore the bad word.
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            pred_d      = expected;
            miss_cnt_d  = miss_inc;
            if (miss_inc == LOSS_CNT) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);

    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = 8'h00;
    end else if (err_inc && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      pred_q         <= 8'h00;
      match_cnt_q    <= 4'd0;
      miss_cnt_q     <= 4'd0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 8'h00;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_count_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      pred_q         <= pred_d;
      match_cnt_q    <= match_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      s1_q           <= tog_in;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      locked_q       <= locked_d;
      err_pulse_q    <= err_pulse_d;
      err_count_q    <= err_count_d;
    end
  end

  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rx_checker
//
// Directed bench for lfsr_rx_checker. It covers the following cases:
//   - reset state
//   - a zero word in HUNT
//   - strobes ignored while disabled
//   - lock acquisition
//   - a single error with flywheel recovery
//   - lock loss and relock
//   - reset while locked
//   - err_count saturation
//   - clear_err arriving together with a mismatch
// -----------------------------------------------------------------------------
module tb_lfsr_rx_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       tog_in;
  logic [7:0] data_in;
  logic       clear_err;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic       got_early, got_sv, got_sv2, got_ep, got_ep2, got_lk, sv_seen;
  logic [7:0] got_sd, got_ec;
  logic [7:0] p;

  always #5 clk = ~clk;

  lfsr_rx_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .tog_in       (tog_in),
    .data_in      (data_in),
    .clear_err    (clear_err),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count)
  );

  function automatic logic [7:0] nx(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One word: data settles for 4 cycles, then the strobe toggles. Outputs are
  // sampled after the 2nd edge (must still be idle), after the 3rd edge (the
  // capture edge) and after the 4th edge (pulses must be gone). clr drives
  // clear_err high only across the capture edge.
  task automatic send(input logic [7:0] d, input logic clr);
    data_in = d;
    repeat (4) @(negedge clk);
    tog_in = ~tog_in;
    @(posedge clk);
    @(posedge clk);
    #1;
    got_early = sample_valid;
    clear_err = clr;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    got_sv = sample_valid;
    got_sd = sample_data;
    got_ep = err_pulse;
    got_lk = locked;
    got_ec = err_count;
    @(posedge clk);
    #1;
    got_sv2 = sample_valid;
    got_ep2 = err_pulse;
    repeat (2) @(negedge clk);
    $display("word %02h: sv=%b sd=%02h ep=%b locked=%b err_count=%02h",
             d, got_sv, got_sd, got_ep, got_lk, got_ec);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; tog_in = 1'b0; data_in = 8'h00; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_sample_valid", sample_valid, 1'b0);
    chk8("rst_sample_data", sample_data, 8'h00);
    chk1("rst_locked", locked, 1'b0);
    chk1("rst_err_pulse", err_pulse, 1'b0);
    chk8("rst_err_count", err_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // A zero word in HUNT is still a sample, but it does not leave HUNT.
    send(8'h00, 1'b0);
    chk1("zero_early", got_early, 1'b0);
    chk1("zero_sv", got_sv, 1'b1);
    chk8("zero_sd", got_sd, 8'h00);
    chk1("zero_locked", got_lk, 1'b0);
    chk1("zero_sv_one_cycle", got_sv2, 1'b0);

    // Lock acquisition. The 5th word (0x11) is delayed by a strobe that is
    // sent while ena=0, to show that the strobe is neither taken nor replayed.
    send(8'h01, 1'b0);
    chk8("lock_sd_01", got_sd, 8'h01);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    send(8'h08, 1'b0);
    chk1("lock_not_yet", got_lk, 1'b0);

    ena = 1'b0;
    data_in = 8'h11;
    repeat (4) @(negedge clk);
    tog_in = ~tog_in;
    sv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      sv_seen = sv_seen | sample_valid;
    end
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      sv_seen = sv_seen | sample_valid;
    end
    $display("strobe with ena=0: sv_seen=%b locked=%b", sv_seen, locked);
    chk1("ena_no_sample", sv_seen, 1'b0);
    chk1("ena_no_state_change", locked, 1'b0);
    @(negedge clk);

    send(8'h11, 1'b0);
    chk1("lock_early", got_early, 1'b0);
    chk1("lock_rises", got_lk, 1'b1);
    chk8("lock_err_count", got_ec, 8'h00);

    // A single error is absorbed by the flywheel.
    send(8'h55, 1'b0);
    chk1("err_pulse", got_ep, 1'b1);
    chk1("err_pulse_one_cycle", got_ep2, 1'b0);
    chk8("err_count_1", got_ec, 8'h01);
    chk1("err_still_locked", got_lk, 1'b1);
    send(8'h47, 1'b0);
    chk1("flywheel_no_err", got_ep, 1'b0);
    chk1("flywheel_locked", got_lk, 1'b1);
    chk8("flywheel_count", got_ec, 8'h01);

    // Lock loss: the prediction is 0x8E, then 0x1C, then 0x38, and 0xAA
    // matches none of them.
    send(8'hAA, 1'b0);
    chk1("loss_m1_locked", got_lk, 1'b1);
    send(8'hAA, 1'b0);
    chk1("loss_m2_locked", got_lk, 1'b1);
    send(8'hAA, 1'b0);
    chk1("loss_m3_unlocked", got_lk, 1'b0);
    chk1("loss_m3_pulse", got_ep, 1'b1);
    chk8("loss_err_count", got_ec, 8'h04);

    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    send(8'h08, 1'b0);
    chk1("relock_not_yet", got_lk, 1'b0);
    send(8'h11, 1'b0);
    chk1("relock", got_lk, 1'b1);

    // Reset while locked.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("reset mid-lock: locked=%b err_count=%02h sd=%02h", locked, err_count, sample_data);
    chk1("midrst_locked", locked, 1'b0);
    chk8("midrst_err_count", err_count, 8'h00);
    chk8("midrst_sample_data", sample_data, 8'h00);
    chk1("midrst_sv", sample_valid, 1'b0);
    chk1("midrst_ep", err_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset, lock must be acquired again from HUNT.
    send(8'h23, 1'b0);
    chk1("midrst_no_lock_on_23", got_lk, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    send(8'h08, 1'b0);
    chk1("midrst_relock_not_yet", got_lk, 1'b0);
    send(8'h11, 1'b0);
    chk1("midrst_relock", got_lk, 1'b1);
    chk8("midrst_relock_count", got_ec, 8'h00);

    // Saturation: two misses and one hit per round keep lock while adding
    // 260 mismatches in total.
    p = 8'h11;
    for (int i = 0; i < 130; i++) begin
      send(~nx(p), 1'b0);
      p = nx(p);
      send(~nx(p), 1'b0);
      p = nx(p);
      send(nx(p), 1'b0);
      p = nx(p);
    end
    chk8("sat_err_count", got_ec, 8'hFF);
    chk1("sat_locked", got_lk, 1'b1);

    // clear_err wins over a simultaneous mismatch.
    send(~nx(p), 1'b1);
    p = nx(p);
    chk1("clr_pulse", got_ep, 1'b1);
    chk8("clr_err_count", got_ec, 8'h00);
    chk1("clr_locked", got_lk, 1'b1);
    send(~nx(p), 1'b0);
    p = nx(p);
    chk8("clr_then_count", got_ec, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
